// File: rtl/iterative_shift_unit_pkg.sv
// ============================================================================
// Module      : iterative_shift_unit_pkg
// Description : Shared mode/state encodings and helpers for the iterative
//               shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iterative_shift_unit_pkg;

    typedef enum logic [2:0] {
        SHIFT_LSL = 3'b000,
        SHIFT_LSR = 3'b001,
        SHIFT_ASR = 3'b010,
        SHIFT_ROL = 3'b011,
        SHIFT_ROR = 3'b100
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Unused encodings collapse onto LSL so the datapath only sees legal modes.
    function automatic shift_mode_e norm_mode(input logic [2:0] m);
        case (m)
            3'b001:  return SHIFT_LSR;
            3'b010:  return SHIFT_ASR;
            3'b011:  return SHIFT_ROL;
            3'b100:  return SHIFT_ROR;
            default: return SHIFT_LSL;
        endcase
    endfunction

    function automatic logic is_rotate(input shift_mode_e m);
        return (m == SHIFT_ROL) || (m == SHIFT_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iterative_shift_unit_shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational single-bit shifter/rotator with bit-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import iterative_shift_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  shift_mode_e      i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bit
);

    always_comb begin
        o_data = i_data;
        o_bit  = 1'b0;
        case (i_mode)
            SHIFT_LSR: begin
                o_data = {1'b0, i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            SHIFT_ASR: begin
                o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            SHIFT_ROL: begin
                o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
                o_bit  = i_data[WIDTH-1];
            end
            SHIFT_ROR: begin
                o_data = {i_data[0], i_data[WIDTH-1:1]};
                o_bit  = i_data[0];
            end
            default: begin
                o_data = {i_data[WIDTH-2:0], 1'b0};
                o_bit  = i_data[WIDTH-1];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/iterative_shift_unit.sv
// ============================================================================
// Module      : iterative_shift_unit
// Description : Multi-cycle shift/rotate unit, one bit per clock, with
//               start/busy/done handshake. Optional macro ISU_FLAGS_EN adds
//               registered zero/neg flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_unit
    import iterative_shift_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] operand,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ISU_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam logic [31:0] C_WIDTH_U = WIDTH;

    state_e           r_state;
    state_e           w_state_next;
    shift_mode_e      r_mode;
    shift_mode_e      w_mode_in;
    shift_mode_e      w_mode_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_eff;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_next;
    logic             r_cout;
    logic             w_cout_next;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_mode (r_mode),
        .i_data (r_result),
        .o_data (w_step_data),
        .o_bit  (w_step_bit)
    );

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept = start && w_ready;

    // Plain shifts saturate at WIDTH; rotates run the full requested count.
    always_comb begin
        w_mode_in = norm_mode(mode);
        w_eff     = amt;
        if (!is_rotate(w_mode_in) && (32'(amt) > C_WIDTH_U)) begin
            w_eff = CNT_W'(WIDTH);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = (w_eff != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_result_next = r_result;
        w_cout_next   = r_cout;
        w_count_next  = r_count;
        w_mode_next   = r_mode;
        if (w_accept) begin
            w_result_next = operand;
            w_cout_next   = 1'b0;
            w_count_next  = w_eff;
            w_mode_next   = w_mode_in;
        end else if (r_state == ST_SHIFT) begin
            w_result_next = w_step_data;
            w_cout_next   = w_step_bit;
            w_count_next  = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= SHIFT_LSL;
            r_count  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mode   <= w_mode_next;
            r_count  <= w_count_next;
            r_result <= w_result_next;
            r_cout   <= w_cout_next;
        end
    end

    assign ready  = w_ready;
    assign busy   = (r_state == ST_SHIFT);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign cout   = r_cout;

`ifdef ISU_FLAGS_EN
    logic r_zero;
    logic r_neg;

    // Flags track the value being written so they line up with result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            r_zero <= (w_result_next == '0);
            r_neg  <= w_result_next[WIDTH-1];
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ============================================================================
// Module      : tb_iterative_shift_unit
// Description : Directed self-checking bench for iterative_shift_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_shift_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [4:0]  amt = 5'd0;
    logic [15:0] operand = 16'h0000;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
`ifdef ISU_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int n_vec = 0;
    int n_miscmp = 0;

    iterative_shift_unit #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .amt     (amt),
        .operand (operand),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout)
`ifdef ISU_FLAGS_EN
        ,
        .zero    (zero),
        .neg     (neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one operation; returns #1 into the cycle where done is seen.
    task automatic do_op(input string tag, input logic [2:0] m, input logic [4:0] a,
                         input logic [15:0] op, input int poke,
                         input logic [15:0] er, input logic ec, input int elat);
        int cyc;
        int nbusy;
        @(negedge clk);
        start = 1'b1; mode = m; amt = a; operand = op;
        @(posedge clk); #1;
        start = 1'b0; mode = 3'b111; amt = 5'h1F; operand = 16'hDEAD;
        cyc = 1;
        nbusy = 0;
        while (!done && cyc <= 64) begin
            if (busy) nbusy++;
            if (cyc == poke) begin
                start = 1'b1; mode = 3'b000; amt = 5'd1; operand = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_lat"},    cyc,    elat);
        chk({tag, "_busy"},   nbusy,  elat - 1);
        chk({tag, "_ready"},  ready,  1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"},   cout,   ec);
    endtask

    task automatic post_idle(input string tag, input logic [15:0] er);
        @(posedge clk); #1;
        chk({tag, "_idle_done"},   done,   0);
        chk({tag, "_idle_ready"},  ready,  1);
        chk({tag, "_idle_result"}, result, er);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_ready",  ready,  1);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_result", result, 0);
        chk("rst_cout",   cout,   0);
        reset = 1'b0;

        do_op("lsl3",   3'b000, 5'd3,  16'h8421, 0, 16'h2108, 1'b0, 4);
        post_idle("lsl3", 16'h2108);
        do_op("asr4",   3'b010, 5'd4,  16'hF0F8, 0, 16'hFF0F, 1'b1, 5);
`ifdef ISU_FLAGS_EN
        chk("asr4_zero", zero, 0);
        chk("asr4_neg",  neg,  1);
`endif
        post_idle("asr4", 16'hFF0F);
        do_op("ror20",  3'b100, 5'd20, 16'h0001, 0, 16'h1000, 1'b0, 21);
        post_idle("ror20", 16'h1000);
        do_op("lsr31",  3'b001, 5'd31, 16'hFFFF, 0, 16'h0000, 1'b1, 17);
        post_idle("lsr31", 16'h0000);
        do_op("amt0",   3'b011, 5'd0,  16'h1234, 0, 16'h1234, 1'b0, 1);
        post_idle("amt0", 16'h1234);
        do_op("poke",   3'b000, 5'd4,  16'h0003, 2, 16'h0030, 1'b0, 5);
        post_idle("poke", 16'h0030);
        do_op("rol1",   3'b011, 5'd1,  16'h8000, 0, 16'h0001, 1'b1, 2);
        post_idle("rol1", 16'h0001);
        do_op("mode5",  3'b101, 5'd2,  16'h0001, 0, 16'h0004, 1'b0, 3);
        do_op("b2b",    3'b001, 5'd1,  16'h0004, 0, 16'h0002, 1'b0, 2);
        post_idle("b2b", 16'h0002);

        @(negedge clk);
        start = 1'b1; mode = 3'b011; amt = 5'd5; operand = 16'h00F0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_ready",  ready,  1);
        chk("mrst_busy",   busy,   0);
        chk("mrst_done",   done,   0);
        chk("mrst_result", result, 0);
        chk("mrst_cout",   cout,   0);
        do_op("after_rst", 3'b000, 5'd1, 16'h0001, 0, 16'h0002, 1'b0, 2);
        post_idle("after_rst", 16'h0002);

`ifdef ISU_FLAGS_EN
        do_op("lsl16", 3'b000, 5'd16, 16'hFFFF, 0, 16'h0000, 1'b1, 17);
        chk("lsl16_zero", zero, 1);
        chk("lsl16_neg",  neg,  0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

`default_nettype wire
